// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types and helpers for the 4-channel round-robin arbiter/mux.
// Used by rr_pick_4 and rr_arb_mux_4.
package rr_arb_pkg;

  localparam int N_CH = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

  // Pointer position just past the granted channel; wraps 3 -> 0.
  function automatic sel_t next_ptr(input sel_t g);
    return sel_t'(g + 2'd1);
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// rr_pick_4: combinational round-robin picker; returns the first requesting
// channel at or after ptr (mod 4), and whether any channel requests.
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  logic [3:0] req,
  input  sel_t       ptr,
  output logic       any,
  output sel_t       g
);

  logic [3:0] rot_s;
  sel_t       off_s;

  // Rotate requests so bit k is channel (ptr+k) mod 4
  always_comb begin
    rot_s = req;
    case (ptr)
      2'd0:    rot_s = req;
      2'd1:    rot_s = {req[0], req[3:1]};
      2'd2:    rot_s = {req[1:0], req[3:2]};
      2'd3:    rot_s = {req[2:0], req[3]};
      default: rot_s = req;
    endcase
  end

  // Fixed-priority encode of the rotated vector gives the offset from ptr
  always_comb begin
    off_s = 2'd0;
    if (rot_s[0]) begin
      off_s = 2'd0;
    end else if (rot_s[1]) begin
      off_s = 2'd1;
    end else if (rot_s[2]) begin
      off_s = 2'd2;
    end else begin
      off_s = 2'd3;
    end
  end

  assign any = |req;
  assign g   = sel_t'(ptr + off_s);

endmodule

// File: rtl/rr_arb_mux_4.sv
// rr_arb_mux_4: 4-channel round-robin arbiter with a registered 4:1 data select
// and a single-entry output register. Define RR_ARB_MUX_GRANT_CNT_EN for grant_cnt.
module rr_arb_mux_4
  import rr_arb_pkg::*;
#(
  parameter int W = 4
`ifdef RR_ARB_MUX_GRANT_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [4*W-1:0]   in_data,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready
`ifdef RR_ARB_MUX_GRANT_CNT_EN
  ,
  output logic [4*CNT_W-1:0] grant_cnt
`endif
);

  arb_state_t   state_r;
  sel_t         ptr_r;
  logic         out_valid_r;
  logic [W-1:0] out_data_r;
  sel_t         out_sel_r;

  logic         any_s;
  sel_t         g_s;
  logic         can_load_s;
  logic         load_s;
  logic [W-1:0] data_mux_s;

  rr_pick_4 u_pick (
    .req (in_valid),
    .ptr (ptr_r),
    .any (any_s),
    .g   (g_s)
  );

  // A drain on this edge frees the register, so a new word may load alongside it
  assign can_load_s = (state_r == EMPTY) | (out_valid_r & out_ready);
  assign load_s     = rst_n & can_load_s & any_s;

  // Grant handshake: one-hot on the picked channel, held low during reset
  always_comb begin
    in_ready = 4'b0000;
    if (load_s) begin
      in_ready[g_s] = 1'b1;
    end else begin
      in_ready = 4'b0000;
    end
  end

  // Data select for the picked channel
  always_comb begin
    data_mux_s = in_data[W-1:0];
    case (g_s)
      2'd0:    data_mux_s = in_data[0*W +: W];
      2'd1:    data_mux_s = in_data[1*W +: W];
      2'd2:    data_mux_s = in_data[2*W +: W];
      2'd3:    data_mux_s = in_data[3*W +: W];
      default: data_mux_s = in_data[W-1:0];
    endcase
  end

  // Output register, arbitration pointer and occupancy state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      ptr_r       <= 2'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= 2'd0;
    end else if (load_s) begin
      state_r     <= FULL;
      ptr_r       <= next_ptr(g_s);
      out_valid_r <= 1'b1;
      out_data_r  <= data_mux_s;
      out_sel_r   <= g_s;
    end else if (out_valid_r && out_ready) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_r;
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

`ifdef RR_ARB_MUX_GRANT_CNT_EN
  logic [3:0][CNT_W-1:0] cnt_r;

  // Per-channel grant counters that stop at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (load_s && (g_s == sel_t'(i)) && (cnt_r[i] != {CNT_W{1'b1}})) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  assign grant_cnt = cnt_r;
`endif

endmodule

// File: doc/rr_arb_mux_4.md
Name: rr_arb_mux_4

Overview:
- 4-channel round-robin arbiter with a registered 4:1 data select and a single-entry output register.
- Sits directly upstream of a 4:1 mux consumer; drives `out_sel` (2-bit select), `out_data` and `out_valid`.
- Each source channel uses a valid/ready handshake. The sink side uses valid/ready with full throughput (one transfer per cycle).

Parameters:
- W, 4, data width per channel and of `out_data`.
- CNT_W, 8, width of each grant counter (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  4  per-channel request; bit i belongs to channel i.
- in_data  in  4*W  packed channel data; channel i occupies [i*W +: W].
- in_ready  out  4  per-channel accept; at most one bit high in any cycle (one-hot or zero).
- out_valid  out  1  output register holds a word.
- out_data  out  W  registered data of the granted channel.
- out_sel  out  2  registered index of the channel that supplied `out_data`.
- out_ready  in  1  sink accepts the output word.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_sel=0, ptr=0, state=EMPTY.
  - in_ready is forced to 0 while rst_n=0.
- States:
  - EMPTY: output register free.
  - FULL: output register holds a word.
- can_load = (state==EMPTY) | (out_valid & out_ready).
- Pick g = first i with in_valid[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 mod 4.
  - in_ready[g] = can_load & |in_valid (combinational).
  - All other in_ready bits are 0.
  - in_ready never depends on in_data.
- Load, when can_load & |in_valid:
  - out_data <= in_data[g]; out_sel <= g; out_valid <= 1; state <= FULL.
  - ptr <= (g+1) mod 4; ptr wraps from 3 to 0.
- Drain without reload (out_valid & out_ready & ~|in_valid):
  - out_valid <= 0; state <= EMPTY; out_data and out_sel hold their last values.
- Stall (FULL & ~out_ready):
  - out_data, out_sel, out_valid and ptr are held.
  - in_ready = 0.
- Simultaneous drain and load: the new word replaces the old in the same edge, with no bubble. Throughput is 1 word/cycle.
- Latency: source handshake at edge k -> word visible on out_* after edge k (1 cycle).
- ptr advances only on a load, never on idle or stall cycles.
- Fairness: with all 4 requesting continuously and out_ready=1, grant order is 0,1,2,3,0,...
- A source may drop in_valid before being granted; the arbiter reselects the next cycle. No lock-in.
- Reset mid-operation: the stored word is discarded, out_valid=0 immediately, ptr=0.

Optional Feature:
- Macro: RR_ARB_MUX_GRANT_CNT_EN.
- Defined:
  - Adds output port grant_cnt, 4*CNT_W, channel i at [i*CNT_W +: CNT_W].
  - Counter i increments on each load with g==i.
  - Counters saturate at all-ones; no wrap.
  - Reset to 0 by rst_n.
- Undefined: the port and counters are absent. All other behaviour is identical.

Decomposition:
- Package rr_arb_pkg:
  - N_CH=4.
  - typedef sel_t = logic [1:0].
  - typedef enum {EMPTY, FULL} arb_state_t.
  - function next_ptr(sel_t) returning (g+1) mod 4.
- Sub-module rr_pick_4: purely combinational.
  - Inputs: req[3:0], ptr (sel_t).
  - Outputs: any (1 bit) and g (sel_t).
  - Instantiated once.

Test Plan:
- Reset: rst_n=0 mid-FULL with out_valid=1 -> out_valid=0, in_ready=0000 while low; after release, first grant scan starts at channel 0.
- Single request: in_valid=0010, in_data ch1=0xB, out_ready=1 -> in_ready=0010 same cycle; next cycle out_valid=1, out_data=0xB, out_sel=1.
- Round-robin: in_valid=1111, data {0xA,0xB,0xC,0xD}, out_ready=1 for 6 cycles -> out_sel sequence 0,1,2,3,0,1; out_data A,B,C,D,A,B; no bubbles.
- Backpressure: FULL with out_sel=2, out_ready=0 for 3 cycles, in_valid=1011 -> in_ready=0000; out_data/out_sel held. Then out_ready=1 -> drain and load ch3 in the same edge; out_sel=3.
- Wrap/skip: ptr=3, in_valid=0101 -> grant ch0 (out_sel=0), ptr=1; next grant ch2.
- With RR_ARB_MUX_GRANT_CNT_EN and CNT_W=2: 5 grants to ch0 -> grant_cnt ch0 = 3 (saturated); other channels 0.
